imm_gen_pipe: RTL and testbench

//  Parametrised, registered immediate generator for the decode stage. Covers all
//  RV32I/RV64I immediate formats (I, S, B, U, J) plus R-type and illegal detection.

---
 rtl/imm_gen_pipe_if.sv | 30 +++
 rtl/imm_gen_pipe.sv | 185 ++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bus for the registered immediate generator: instruction + tag in,
// sign-extended immediate + format + tag out.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  // Driver side: feeds instructions and consumes results.
  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  // The immediate generator itself.
  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator with a one-entry skid buffer so
// downstream back-pressure never drops an instruction; in_ready is a pure flop.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  imm_gen_pipe_if.slave     bus
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam entry_t ENTRY_RST = '{imm: '0, fmt: FMT_R, illegal: 1'b0, tag: '0};

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming word
  // ---------------------------------------------------------------------------
  logic [31:0] instr;
  logic [6:0]  opcode;
  fmt_e        dec_fmt;
  logic        dec_illegal;
  logic [31:0] imm32;
  logic [XLEN-1:0] dec_imm;
  entry_t      dec;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];

  // NOTE: every always_comb output gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    dec_fmt     = FMT_ILL;
    dec_illegal = 1'b1;
    unique case (opcode)
      7'b0000011, 7'b0010011, 7'b1100111,
      7'b1110011, 7'b0001111: begin
        dec_fmt     = FMT_I;
        dec_illegal = 1'b0;
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          dec_fmt     = FMT_I;
          dec_illegal = 1'b0;
        end
      end
      7'b0100011: begin
        dec_fmt     = FMT_S;
        dec_illegal = 1'b0;
      end
      7'b1100011: begin
        dec_fmt     = FMT_B;
        dec_illegal = 1'b0;
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt     = FMT_U;
        dec_illegal = 1'b0;
      end
      7'b1101111: begin
        dec_fmt     = FMT_J;
        dec_illegal = 1'b0;
      end
      7'b0110011: begin
        dec_fmt     = FMT_R;
        dec_illegal = 1'b0;
      end
      7'b0111011: begin
        if (XLEN == 64) begin
          dec_fmt     = FMT_R;
          dec_illegal = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Shift-immediates are deliberately not masked: the raw I field is emitted.
  always_comb begin
    imm32 = '0;
    unique case (dec_fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Bit 31 of every format is instr[31] (or 0 for R/illegal), so it is the sign.
  always_comb begin
    dec_imm       = {XLEN{imm32[31]}};
    dec_imm[31:0] = imm32;
  end

  always_comb begin
    dec         = ENTRY_RST;
    dec.imm     = dec_imm;
    dec.fmt     = dec_fmt;
    dec.illegal = dec_illegal;
    dec.tag     = bus.in_tag;
  end

  // ---------------------------------------------------------------------------
  // Main (M) and skid (K) registers
  // ---------------------------------------------------------------------------
  logic   m_valid, k_valid;
  entry_t m_q, k_q;
  logic   accept, drain, m_free;

  assign accept = bus.in_valid && !k_valid;
  assign drain  = m_valid && bus.out_ready;
  assign m_free = !m_valid || drain;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      k_valid <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
      k_valid <= 1'b0;
    end else if (m_free) begin
      // K is older than anything on the input, so it refills M first; accept
      // is impossible while K is full, so nothing is lost here.
      if (k_valid) begin
        m_valid <= 1'b1;
        k_valid <= 1'b0;
      end else begin
        m_valid <= accept;
      end
    end else if (accept) begin
      k_valid <= 1'b1;
    end
  end

  // NOTE: the payload registers are reset because the outputs must read zero
  // after reset; otherwise they would only need a load enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= ENTRY_RST;
      k_q <= ENTRY_RST;
    end else if (!flush) begin
      if (m_free) begin
        if (k_valid) begin
          m_q <= k_q;
        end else if (accept) begin
          m_q <= dec;
        end
      end else if (accept) begin
        k_q <= dec;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: straight from registers, no combinational path from out_ready
  // ---------------------------------------------------------------------------
  assign bus.in_ready    = !k_valid;
  assign bus.out_valid   = m_valid;
  assign bus.out_imm     = m_q.imm;
  assign bus.out_fmt     = m_q.fmt;
  assign bus.out_illegal = m_q.illegal;
  assign bus.out_tag     = m_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode vectors for XLEN=32/64, back-pressure,
// throughput, reset and flush.
module tb_imm_gen_pipe;

  localparam int TAG_W = 8;

  logic clk;
  logic rst_n;
  logic flush;

  int errors = 0;
  int checks = 0;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(TAG_W)) if32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(TAG_W)) if64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (if32.slave)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (if64.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction with out_ready=1; result is visible one edge later.
  task automatic send32(input logic [31:0] instr, input logic [7:0] tag);
    if32.in_instr  = instr;
    if32.in_tag    = tag;
    if32.in_valid  = 1'b1;
    if32.out_ready = 1'b1;
    tick();
    if32.in_valid  = 1'b0;
  endtask

  task automatic send64(input logic [31:0] instr, input logic [7:0] tag);
    if64.in_instr  = instr;
    if64.in_tag    = tag;
    if64.in_valid  = 1'b1;
    if64.out_ready = 1'b1;
    tick();
    if64.in_valid  = 1'b0;
  endtask

  task automatic check32(input string name, input logic [31:0] instr,
                         input logic [31:0] imm, input logic [2:0] fmt,
                         input logic ill, input logic [7:0] tag);
    send32(instr, tag);
    check({name, ".valid"},   64'(if32.out_valid),   64'd1);
    check({name, ".imm"},     64'(if32.out_imm),     64'(imm));
    check({name, ".fmt"},     64'(if32.out_fmt),     64'(fmt));
    check({name, ".illegal"}, 64'(if32.out_illegal), 64'(ill));
    check({name, ".tag"},     64'(if32.out_tag),     64'(tag));
  endtask

  // Streams n tags starting at first_tag; out_ready is held low for the first
  // stall cycles. Collected tags and handshake behaviour are checked.
  task automatic run_stream(input string name, input int n, input int first_tag,
                            input int stall);
    int q[$];
    int sent = 0;
    int cyc  = 0;
    int run  = 0;
    int best = 0;
    bit acc;
    while (q.size() < n && cyc < 200) begin
      if32.in_valid  = (sent < n);
      if32.in_instr  = 32'h00100093;
      if32.in_tag    = 8'(first_tag + sent);
      if32.out_ready = (cyc >= stall);
      #1;
      if (stall > 0 && cyc == 2)
        check({name, ".in_ready_drop"}, 64'(if32.in_ready), 64'd0);
      acc = if32.in_valid && if32.in_ready;
      if (if32.out_valid && if32.out_ready) q.push_back(int'(if32.out_tag));
      if (if32.out_valid) begin
        run++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
      tick();
      if (acc) sent++;
      cyc++;
    end
    if32.in_valid  = 1'b0;
    if32.out_ready = 1'b1;
    check({name, ".count"}, 64'(q.size()), 64'(n));
    for (int i = 0; i < q.size(); i++)
      check($sformatf("%s.tag%0d", name, i), 64'(q[i]), 64'(first_tag + i));
    if (stall == 0) begin
      check({name, ".consecutive"}, 64'(best), 64'(n));
      #1;
      check({name, ".idle_after"}, 64'(if32.out_valid), 64'd0);
    end
  endtask

  int seen55;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    if32.in_valid = 1'b0; if32.in_instr = '0; if32.in_tag = '0; if32.out_ready = 1'b1;
    if64.in_valid = 1'b0; if64.in_instr = '0; if64.in_tag = '0; if64.out_ready = 1'b1;
    #1;
    check("rst.out_valid", 64'(if32.out_valid), 64'd0);
    check("rst.in_ready",  64'(if32.in_ready),  64'd1);
    check("rst.imm",       64'(if32.out_imm),   64'd0);
    check("rst.fmt",       64'(if32.out_fmt),   64'd0);
    check("rst.tag",       64'(if32.out_tag),   64'd0);
    #20;
    rst_n = 1'b1;
    tick();

    // I / S / B
    check32("lw",  32'hFFC12083, 32'hFFFFFFFC, 3'd1, 1'b0, 8'h11);
    check32("sw",  32'h00512423, 32'h00000008, 3'd2, 1'b0, 8'h12);
    check32("beq", 32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0, 8'h13);
    // U / J / illegal / R
    check32("lui", 32'h123450B7, 32'h12345000, 3'd4, 1'b0, 8'h14);
    check32("jal", 32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 1'b0, 8'h15);
    check32("ill", 32'h0000007F, 32'h00000000, 3'd7, 1'b1, 8'h16);
    check32("add", 32'h00B50533, 32'h00000000, 3'd0, 1'b0, 8'h17);
    // RV64-only opcodes are illegal in a 32-bit build
    check32("addiw32", 32'h0000001B, 32'h00000000, 3'd7, 1'b1, 8'h18);
    tick();

    // Back-pressure and throughput
    run_stream("bp", 4, 1, 3);
    tick();
    run_stream("tput", 16, 32, 0);
    tick();

    // Asynchronous reset with both M and K occupied
    if32.out_ready = 1'b0;
    if32.in_valid  = 1'b1;
    if32.in_instr  = 32'hFFC12083;
    if32.in_tag    = 8'h21;
    tick();
    if32.in_tag    = 8'h22;
    tick();
    if32.in_valid  = 1'b0;
    check("full.in_ready",  64'(if32.in_ready),  64'd0);
    check("full.out_valid", 64'(if32.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.out_valid", 64'(if32.out_valid), 64'd0);
    check("arst.in_ready",  64'(if32.in_ready),  64'd1);
    check("arst.imm",       64'(if32.out_imm),   64'd0);
    check("arst.tag",       64'(if32.out_tag),   64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Flush with M occupied and a new instruction presented the same cycle
    if32.out_ready = 1'b0;
    send32(32'h00100093, 8'h44);
    if32.out_ready = 1'b0;
    if32.in_valid  = 1'b1;
    if32.in_tag    = 8'h55;
    flush          = 1'b1;
    tick();
    flush          = 1'b0;
    if32.in_valid  = 1'b0;
    if32.out_ready = 1'b1;
    check("flush.out_valid", 64'(if32.out_valid), 64'd0);
    check("flush.in_ready",  64'(if32.in_ready),  64'd1);
    seen55 = 0;
    for (int i = 0; i < 4; i++) begin
      if (if32.out_valid && if32.out_tag == 8'h55) seen55++;
      tick();
    end
    check("flush.no_ghost", 64'(seen55), 64'd0);

    // XLEN=64 build
    send64(32'h800000B7, 8'h61);
    check("lui64.valid", 64'(if64.out_valid), 64'd1);
    check("lui64.imm",   if64.out_imm,        64'hFFFFFFFF80000000);
    check("lui64.fmt",   64'(if64.out_fmt),   64'd4);
    send64(32'h0000001B, 8'h62);
    check("addiw.fmt",     64'(if64.out_fmt),     64'd1);
    check("addiw.illegal", 64'(if64.out_illegal), 64'd0);
    check("addiw.tag",     64'(if64.out_tag),     64'h62);
    send64(32'h0000003B, 8'h63);
    check("addw.fmt", 64'(if64.out_fmt), 64'd0);
    check("addw.imm", if64.out_imm,      64'd0);
    send64(32'hFFC12083, 8'h64);
    check("lw64.imm", if64.out_imm, 64'hFFFFFFFFFFFFFFFC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
